// File: rtl/multicore_ctrl_pkg.sv
// Shared definitions for multicore_ctrl: command field layout, default
// stall counts and the core-ID width helper.
package multicore_ctrl_pkg;

  localparam logic [2:0] PAUSE_STALL_DEF = 3'd6;
  localparam logic [2:0] WR_STALL_DEF    = 3'd6;
  localparam logic [2:0] RD_STALL_DEF    = 3'd3;

  // Command slice layout: {valid, run, target[cw-1:0]}
  localparam int CMD_TARGET_OFS = 0;

  function automatic int cmd_run_ofs(input int cw);
    return cw;
  endfunction

  function automatic int cmd_valid_ofs(input int cw);
    return cw + 1;
  endfunction

  function automatic int cmd_width(input int cw);
    return cw + 2;
  endfunction

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multicore_ctrl_rr_arbiter.sv
// Zero-latency round-robin arbiter; the pointer moves one past the winner.
module rr_arbiter
  import multicore_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = id_width(N);

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;
  logic          found;
  int            idx;

  always_comb begin
    grant    = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_reg) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = PW'((idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_reg <= '0;
    else       ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/multicore_ctrl.sv
// Pause/resume control of NCORES cores, shared write/read port arbitration
// with per-core stall counts, and a sticky all-halted flag.
module multicore_ctrl
  import multicore_ctrl_pkg::*;
#(
  parameter int               NCORES      = 4,
  parameter int               CW          = id_width(NCORES),
  parameter logic [NCORES-1:0] RESET_RUN  = {NCORES{1'b1}},
  parameter logic [2:0]       PAUSE_STALL = PAUSE_STALL_DEF,
  parameter logic [2:0]       WR_STALL    = WR_STALL_DEF,
  parameter logic [2:0]       RD_STALL    = RD_STALL_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCORES-1:0]        core_halt,
  input  logic [NCORES*(CW+2)-1:0] pr_cmd,
  input  logic [NCORES-1:0]        wen,
  input  logic [NCORES-1:0]        rd_req,
  output logic [NCORES-1:0]        running,
  output logic [NCORES*3-1:0]      stall_num,
  output logic [NCORES-1:0]        wr_grant,
  output logic [NCORES-1:0]        rd_grant,
  output logic                     halt_all
);

  localparam int CMDW = cmd_width(CW);

  logic [NCORES-1:0] running_reg;
  logic              halt_all_reg;
  logic [NCORES-1:0] accepted;
  logic [NCORES-1:0] cmd_run;
  logic [CW-1:0]     cmd_tgt [NCORES];
  logic [NCORES-1:0] hit, run_sel, pause_any, resume_any;
  logic [NCORES-1:0] pause_blocked, wr_elig, rd_elig;

  genvar gi;
  generate
    for (gi = 0; gi < NCORES; gi++) begin : g_cmd
      assign cmd_tgt[gi]  = pr_cmd[gi*CMDW + CMD_TARGET_OFS +: CW];
      assign cmd_run[gi]  = pr_cmd[gi*CMDW + cmd_run_ofs(CW)];
      assign accepted[gi] = pr_cmd[gi*CMDW + cmd_valid_ofs(CW)] && running_reg[gi]
                            && (int'(cmd_tgt[gi]) < NCORES);
    end
  endgenerate

  // Lowest-index accepted command wins the run state; any accepted pause blocks.
  always_comb begin
    hit        = '0;
    run_sel    = '0;
    pause_any  = '0;
    resume_any = '0;
    for (int t = 0; t < NCORES; t++) begin
      for (int i = 0; i < NCORES; i++) begin
        if (accepted[i] && cmd_tgt[i] == CW'(t)) begin
          if (!hit[t]) run_sel[t] = cmd_run[i];
          hit[t] = 1'b1;
          if (cmd_run[i]) resume_any[t] = 1'b1;
          else            pause_any[t]  = 1'b1;
        end
      end
    end
  end

  assign pause_blocked = pause_any | (~running_reg & ~resume_any);
  assign wr_elig       = wen & ~pause_blocked;
  assign rd_elig       = rd_req & ~pause_blocked;

  rr_arbiter #(.N(NCORES)) u_wr_arb (
    .clk   (clk),
    .reset (reset),
    .req   (wr_elig),
    .grant (wr_grant)
  );

  rr_arbiter #(.N(NCORES)) u_rd_arb (
    .clk   (clk),
    .reset (reset),
    .req   (rd_elig),
    .grant (rd_grant)
  );

  generate
    for (gi = 0; gi < NCORES; gi++) begin : g_stall
      assign stall_num[gi*3 +: 3] =
          pause_blocked[gi]                ? PAUSE_STALL :
          (wen[gi]    && !wr_grant[gi])    ? WR_STALL    :
          (rd_req[gi] && !rd_grant[gi])    ? RD_STALL    : 3'd0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      running_reg  <= RESET_RUN;
      halt_all_reg <= 1'b0;
    end else begin
      for (int t = 0; t < NCORES; t++) begin
        if (hit[t]) running_reg[t] <= run_sel[t];
      end
      if (&core_halt) halt_all_reg <= 1'b1;
    end
  end

  assign running  = running_reg;
  assign halt_all = halt_all_reg;

endmodule

// File: tb/tb_multicore_ctrl.sv
// Directed vector bench for multicore_ctrl (NCORES=4, RESET_RUN=4'b1111).
module tb_multicore_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  core_halt;
  logic [15:0] pr_cmd;
  logic [3:0]  wen, rd_req;
  logic [3:0]  running, wr_grant, rd_grant;
  logic [11:0] stall_num;
  logic        halt_all;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicore_ctrl #(.NCORES(4), .RESET_RUN(4'b1111)) dut (
    .clk       (clk),
    .reset     (reset),
    .core_halt (core_halt),
    .pr_cmd    (pr_cmd),
    .wen       (wen),
    .rd_req    (rd_req),
    .running   (running),
    .stall_num (stall_num),
    .wr_grant  (wr_grant),
    .rd_grant  (rd_grant),
    .halt_all  (halt_all)
  );

  typedef struct packed {
    logic        rst;
    logic [3:0]  halt;
    logic [15:0] cmd;
    logic [3:0]  wen;
    logic [3:0]  rd;
    logic [3:0]  e_run;
    logic [11:0] e_stall;
    logic [3:0]  e_wg;
    logic [3:0]  e_rg;
    logic        e_halt;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input int id, input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, id, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] h, input logic [15:0] c,
                       input logic [3:0] w, input logic [3:0] r);
    @(negedge clk);
    reset = rst; core_halt = h; pr_cmd = c; wen = w; rd_req = r;
    #1;
  endtask

  task automatic check_all(input int id, input logic [3:0] e_run, input logic [11:0] e_stall,
                           input logic [3:0] e_wg, input logic [3:0] e_rg, input logic e_halt);
    check("running",   id, 16'(running),   16'(e_run));
    check("stall_num", id, 16'(stall_num), 16'(e_stall));
    check("wr_grant",  id, 16'(wr_grant),  16'(e_wg));
    check("rd_grant",  id, 16'(rd_grant),  16'(e_rg));
    check("halt_all",  id, 16'(halt_all),  16'(e_halt));
    $display("vec %0d: cmd=%h wen=%b rd=%b -> run=%b stall=%h wg=%b rg=%b halt=%b",
             id, pr_cmd, wen, rd_req, running, stall_num, wr_grant, rd_grant, halt_all);
  endtask

  initial begin
    // rst halt cmd wen rd | run stall wg rg halt
    vecs[0]  = '{1'b1, 4'h0, 16'h0000, 4'b0000, 4'b0000, 4'b1111, 12'h000, 4'b0000, 4'b0000, 1'b0};
    vecs[1]  = '{1'b0, 4'h0, 16'h0000, 4'b1111, 4'b0000, 4'b1111, 12'hDB0, 4'b0001, 4'b0000, 1'b0};
    vecs[2]  = '{1'b0, 4'h0, 16'h0000, 4'b1111, 4'b0000, 4'b1111, 12'hD86, 4'b0010, 4'b0000, 1'b0};
    vecs[3]  = '{1'b0, 4'h0, 16'h0000, 4'b1111, 4'b0000, 4'b1111, 12'hC36, 4'b0100, 4'b0000, 1'b0};
    vecs[4]  = '{1'b0, 4'h0, 16'h0000, 4'b1111, 4'b0000, 4'b1111, 12'h1B6, 4'b1000, 4'b0000, 1'b0};
    vecs[5]  = '{1'b0, 4'h0, 16'h000A, 4'b0000, 4'b0000, 4'b1111, 12'h180, 4'b0000, 4'b0000, 1'b0};
    vecs[6]  = '{1'b0, 4'h0, 16'h0000, 4'b0000, 4'b0000, 4'b1011, 12'h180, 4'b0000, 4'b0000, 1'b0};
    vecs[7]  = '{1'b0, 4'h0, 16'h00E0, 4'b0000, 4'b0000, 4'b1011, 12'h000, 4'b0000, 4'b0000, 1'b0};
    vecs[8]  = '{1'b0, 4'h0, 16'h0000, 4'b0000, 4'b0000, 4'b1111, 12'h000, 4'b0000, 4'b0000, 1'b0};
    vecs[9]  = '{1'b0, 4'h0, 16'hC080, 4'b0000, 4'b0000, 4'b1111, 12'h006, 4'b0000, 4'b0000, 1'b0};
    vecs[10] = '{1'b0, 4'h0, 16'h00A0, 4'b0000, 4'b0000, 4'b1110, 12'h186, 4'b0000, 4'b0000, 1'b0};
    vecs[11] = '{1'b0, 4'h0, 16'h0E00, 4'b0000, 4'b0000, 4'b1010, 12'h186, 4'b0000, 4'b0000, 1'b0};
    vecs[12] = '{1'b0, 4'h0, 16'hE0C0, 4'b0000, 4'b0000, 4'b1010, 12'h000, 4'b0000, 4'b0000, 1'b0};
    vecs[13] = '{1'b0, 4'h0, 16'h0000, 4'b0000, 4'b0110, 4'b1111, 12'h0C0, 4'b0000, 4'b0010, 1'b0};
    vecs[14] = '{1'b0, 4'h0, 16'h0000, 4'b0000, 4'b0110, 4'b1111, 12'h018, 4'b0000, 4'b0100, 1'b0};
    vecs[15] = '{1'b0, 4'h0, 16'h0000, 4'b0001, 4'b0001, 4'b1111, 12'h000, 4'b0001, 4'b0001, 1'b0};
    vecs[16] = '{1'b0, 4'hF, 16'h0000, 4'b0000, 4'b0000, 4'b1111, 12'h000, 4'b0000, 4'b0000, 1'b0};
    vecs[17] = '{1'b0, 4'h0, 16'h0000, 4'b0000, 4'b0000, 4'b1111, 12'h000, 4'b0000, 4'b0000, 1'b1};
    vecs[18] = '{1'b1, 4'h0, 16'h00A0, 4'b0000, 4'b0000, 4'b1111, 12'h180, 4'b0000, 4'b0000, 1'b1};
    vecs[19] = '{1'b0, 4'h0, 16'h0000, 4'b0010, 4'b1000, 4'b1111, 12'h000, 4'b0010, 4'b1000, 1'b0};

    reset = 1'b1; core_halt = '0; pr_cmd = '0; wen = '0; rd_req = '0;
    repeat (2) @(posedge clk);

    for (int v = 0; v < NV; v++) begin
      drive(vecs[v].rst, vecs[v].halt, vecs[v].cmd, vecs[v].wen, vecs[v].rd);
      check_all(v, vecs[v].e_run, vecs[v].e_stall, vecs[v].e_wg, vecs[v].e_rg, vecs[v].e_halt);
    end

    // Core 3 pauses itself while requesting the write port: no grant, stall 6.
    drive(1'b0, 4'h0, 16'hB000, 4'b1000, 4'b0000);
    check_all(100, 4'b1111, 12'hC00, 4'b0000, 4'b0000, 1'b0);
    // Paused on the next edge; reset asserted mid-pause.
    drive(1'b1, 4'h0, 16'h0000, 4'b1000, 4'b0000);
    check_all(101, 4'b0111, 12'hC00, 4'b0000, 4'b0000, 1'b0);
    // Reset restored the run state and the write pointer.
    drive(1'b0, 4'h0, 16'h0000, 4'b1000, 4'b0000);
    check_all(102, 4'b1111, 12'h000, 4'b1000, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
